// File: rtl/sd_pkg.sv
// Shared state encoding, command indices and R1 constants for the SPI-mode SD
// command host and its clock generator.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        CMD,
        WAIT_R,
        RESP,
        POST,
        DONE
    } sd_state_t;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [7:0] R1_IDLE  = 8'h01;
    localparam logic [7:0] R1_READY = 8'h00;
    localparam logic [7:0] R1_NONE  = 8'hFF;

    localparam int FRAME_W = 48;
    localparam int R1_W    = 8;

    // Start bit, transmission bit, index, argument, CRC7 and end bit.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [5:0]  index,
                                                       input logic [31:0] arg,
                                                       input logic [6:0]  crc);
        return {2'b01, index, arg, crc, 1'b1};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sd_spi_clkgen.sv
// SD_CLK generator: divides the system clock while enabled and flags each
// rising and falling SD_CLK edge with a one-clk strobe.
module sd_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sd_clk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] half_cnt;
    logic             toggle;

    // Strobes are asserted in the clk whose edge flips sd_clk.
    assign toggle   = enable && (half_cnt == CNT_LAST);
    assign rise_stb = toggle && !sd_clk;
    assign fall_stb = toggle && sd_clk;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            half_cnt <= '0;
            sd_clk   <= 1'b0;
        end else if (toggle) begin
            half_cnt <= '0;
            sd_clk   <= ~sd_clk;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sd_spi_cmd_host.sv
// Host-side SPI-mode SD command engine: sends one 48-bit command frame and
// hunts for the card's R1 response, reporting done/timeout.
module sd_spi_cmd_host
    import sd_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int NCR_MAX    = 8,
    parameter int PRE_BYTES  = 1,
    parameter int POST_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    output logic        busy,
    output logic        done,
    output logic [7:0]  resp,
    output logic        timeout,
    output logic        sd_clk,
    output logic        sd_cs_n,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    localparam int MAX_RISES = max_int(max_int(PRE_BYTES * 8, FRAME_W),
                                       max_int(NCR_MAX * 8, POST_BYTES * 8));
    localparam int CNT_W = $clog2(MAX_RISES + 1);

    localparam logic [CNT_W-1:0] PRE_RISES   = CNT_W'(PRE_BYTES * 8);
    localparam logic [CNT_W-1:0] FRAME_RISES = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] POLL_RISES  = CNT_W'(NCR_MAX * 8);
    localparam logic [CNT_W-1:0] RESP_RISES  = CNT_W'(R1_W - 1);
    localparam logic [CNT_W-1:0] POST_RISES  = CNT_W'(POST_BYTES * 8);

    sd_state_t          state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [R1_W-1:0]    shift_q, shift_d;
    logic [R1_W-1:0]    resp_q, resp_d;
    logic               timeout_q, timeout_d;
    logic               mosi_q, mosi_d;
    logic               clk_en;
    logic               rise_stb;
    logic               fall_stb;

    assign clk_en  = (state_q != IDLE) && (state_q != DONE);
    assign cnt_inc = cnt_q + 1'b1;

    sd_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .enable   (clk_en),
        .sd_clk   (sd_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '1;
            cnt_q     <= '0;
            shift_q   <= R1_NONE;
            resp_q    <= R1_NONE;
            timeout_q <= 1'b0;
            mosi_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            mosi_q    <= mosi_d;
        end
    end

    // cnt_q counts rising SD_CLK edges within the current phase; mosi only moves on falls.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        mosi_d    = mosi_q;

        unique case (state_q)
            IDLE: begin
                mosi_d = 1'b1;
                if (cmd_start) begin
                    frame_d = build_frame(cmd_index, cmd_arg, cmd_crc);
                    cnt_d   = '0;
                    if (PRE_BYTES == 0) begin
                        mosi_d  = frame_d[FRAME_W-1];
                        frame_d = {frame_d[FRAME_W-2:0], 1'b1};
                        state_d = CMD;
                    end else begin
                        state_d = PRE;
                    end
                end
            end

            PRE: begin
                if (rise_stb) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == PRE_RISES) begin
                        cnt_d   = '0;
                        state_d = CMD;
                    end
                end
            end

            CMD: begin
                if (fall_stb) begin
                    mosi_d  = frame_q[FRAME_W-1];
                    frame_d = {frame_q[FRAME_W-2:0], 1'b1};
                end else if (rise_stb) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FRAME_RISES) begin
                        cnt_d   = '0;
                        state_d = WAIT_R;
                    end
                end
            end

            // A sampled 0 is the R1 start bit and becomes resp[7].
            WAIT_R: begin
                if (fall_stb) begin
                    mosi_d = 1'b1;
                end else if (rise_stb) begin
                    if (!sd_miso) begin
                        shift_d = {shift_q[R1_W-2:0], sd_miso};
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == POLL_RISES) begin
                            resp_d    = R1_NONE;
                            timeout_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = POST;
                        end
                    end
                end
            end

            RESP: begin
                if (fall_stb) begin
                    mosi_d = 1'b1;
                end else if (rise_stb) begin
                    shift_d = {shift_q[R1_W-2:0], sd_miso};
                    cnt_d   = cnt_inc;
                    if (cnt_inc == RESP_RISES) begin
                        resp_d    = {shift_q[R1_W-2:0], sd_miso};
                        timeout_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = POST;
                    end
                end
            end

            // The fall after the last trailing rise releases CS and parks SD_CLK low.
            POST: begin
                if (rise_stb) begin
                    cnt_d = cnt_inc;
                end else if (fall_stb) begin
                    mosi_d = 1'b1;
                    if (cnt_q == POST_RISES) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = clk_en;
    assign done    = (state_q == DONE);
    assign resp    = resp_q;
    assign timeout = timeout_q;
    assign sd_cs_n = !clk_en;
    assign sd_mosi = mosi_q;

endmodule

// File: doc/sd_spi_cmd_host.md
Name: sd_spi_cmd_host

Overview:
- Host-side SPI-mode SD command engine; the counterpart of the card-side R1 responder used on the bench.
- Takes one command request from the SD init/read/write sequencers and drives the card's SD_CLK, chip select and data-in pin.
- Serialises the 48-bit command frame MSB first, then hunts for the card's R1 byte on the card's data-out pin and returns it with done/timeout status.
- Sits between `sd_initial` (and later the read/write sequencers) and the card pins.

Parameters:
- CLK_DIV, 4, system clocks per SD_CLK half-period (>=1).
- NCR_MAX, 8, max response bytes polled before timeout (>=1).
- PRE_BYTES, 1, dummy 0xFF bytes clocked with CS low before the frame.
- POST_BYTES, 1, dummy 0xFF bytes clocked after R1 before CS release.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle request; accepted only when busy=0.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- cmd_crc  in  7  CRC7 supplied by the caller; not computed here.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-clk pulse at completion.
- resp  out  8  R1 byte; held until the next accepted start.
- timeout  out  1  valid with done; held with resp.
- sd_clk  out  1  SD_CLK to the card.
- sd_cs_n  out  1  card select, active low.
- sd_mosi  out  1  drives the card's SD_IN.
- sd_miso  in  1  reads the card's SD_OUT.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Outputs: sd_clk=0, sd_cs_n=1, sd_mosi=1, busy=0, done=0, resp=8'hFF, timeout=0.
  - State returns to IDLE from any state. No partial frame resumes.
- SD_CLK generation:
  - A half-period counter counts CLK_DIV clks and toggles sd_clk, but only when state is not IDLE/DONE.
  - Each toggle produces a one-clk rise or fall strobe.
  - sd_mosi changes only on fall strobes; sd_miso is sampled only on rise strobes (SPI mode 0). The card model shifts on negedge.
- Frame content: 48 bits = {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1}, latched on accept, sent MSB first.
  - Example: CMD0 with arg 0 and CRC 7'h4A gives 48'h40_0000_0000_95.
- State machine:
  - IDLE: sd_cs_n=1, sd_mosi=1. On cmd_start: latch frame, set busy=1, drop sd_cs_n, go to PRE.
  - PRE: clock PRE_BYTES*8 rising edges with sd_mosi=1, then go to CMD. If PRE_BYTES=0, go straight to CMD.
  - CMD:
    - frame[47] is presented on sd_mosi before the first CMD rise.
    - Each fall strobe shifts to the next bit.
    - After the 48th rise, go to WAIT_R and drive sd_mosi=1 from the next fall.
  - WAIT_R:
    - On each rise, sample sd_miso.
    - 0 sampled: this is resp[7] (the R1 start bit); load it and go to RESP with 7 bits remaining.
    - 1 sampled: count the edge. When the count reaches NCR_MAX*8, set resp=8'hFF, set timeout=1, go to POST.
  - RESP: shift 7 further rising-edge samples into resp (MSB first), then go to POST with timeout=0.
  - POST: clock POST_BYTES*8 rises with sd_mosi=1. Then on the next fall, set sd_cs_n=1 and sd_clk=0, and go to DONE.
  - DONE: pulse done=1 for one clk, set busy=0, return to IDLE.
- cmd_start while busy=1 is ignored (no queueing).
- cmd_start in the same clk as done is ignored; it must be reasserted in IDLE.
- Latency with CLK_DIV=4 and defaults: (8+48+8n+8+8) SD_CLK periods, where n is the number of response byte positions polled.
- resp and timeout stay stable between done and the next accept.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding: IDLE, PRE, CMD, WAIT_R, RESP, POST, DONE.
  - command indices: CMD0=0, CMD8=8, CMD55=55, ACMD41=41.
  - R1 constants: R1_IDLE=8'h01, R1_READY=8'h00, R1_NONE=8'hFF.
  - widths: FRAME_W=48, R1_W=8.
- One natural sub-module: sd_spi_clkgen (half-period counter, sd_clk register, rise/fall strobes, enable input).

Test Plan:
- CMD0, arg 0, crc 7'h4A, card answers 8'h01 in the second byte position → mosi frame 48'h400000000095, resp=8'h01, timeout=0, one-clk done pulse, sd_cs_n high after.
- CMD55, arg 0, crc 7'h32; card answers R1 8'h01 immediately → mosi frame 48'h770000000065; resp=8'h01; response captured within 8 rises of the frame end.
- Card never drives 0, NCR_MAX=8 → after 64 polled rises, resp=8'hFF, timeout=1, done pulses, sd_cs_n=1.
- Second cmd_start asserted mid-CMD with a different index → ignored; frame unchanged; exactly one done.
- rst asserted at frame bit 20 → next clk: sd_cs_n=1, sd_mosi=1, sd_clk=0, busy=0; a new CMD8 (arg 32'h1AA, crc 7'h43) then completes normally.
- CLK_DIV=1 with the CMD0 scenario → sd_clk toggles every clk; same bitstream and resp=8'h01.
